// File: rtl/store_commit_buffer.sv
// ---------------------------------------------------------------------------
// store_commit_buffer
//
// Post-commit store queue between the ROB head and the data cache. Retired
// stores are pushed in program order into a circular FIFO and drained to the
// cache one at a time, so a busy cache only stalls retirement once the
// buffer is full. The MEM stage gets a same-cycle word-overlap check against
// every buffered store and, optionally, word store-to-load forwarding.
//
// Optional feature macro: SB_FORWARD_EN
//   defined   -> load_fwd_valid/load_fwd_data forward the youngest matching
//                aligned word store whose address equals the load address
//   undefined -> load_fwd_valid/load_fwd_data are tied to 0
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// sides are high. ROB side: store_valid_ROB/store_accept_ROB, accept does not
// depend on store_valid_ROB or DM_ready. Cache side: MemWrite_2DM/DM_ready,
// once MemWrite_2DM is raised the address/data/size hold stable until the
// edge where DM_ready is seen high.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-low reset
//   store_*_ROB                committed store in / accept out
//   MemWrite_2DM, data_*_2DM   registered write request to the cache
//   DM_ready                   cache accepts the presented write
//   load_check_addr_MEM        address of the load in MEM
//   load_conflict              a buffered store overlaps the load's word
//   load_fwd_valid/_data       forwarded word (optional feature)
//   sb_count, sb_empty         occupancy from registered state
// ---------------------------------------------------------------------------
module store_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     store_valid_ROB,
  input  logic [ADDR_W-1:0]        store_addr_ROB,
  input  logic [DATA_W-1:0]        store_data_ROB,
  input  logic [1:0]               store_size_ROB,
  output logic                     store_accept_ROB,
  output logic                     MemWrite_2DM,
  output logic [ADDR_W-1:0]        data_address_2DM,
  output logic [DATA_W-1:0]        data_write_2DM,
  output logic [1:0]               data_write_size_2DM,
  input  logic                     DM_ready,
  input  logic [ADDR_W-1:0]        load_check_addr_MEM,
  output logic                     load_conflict,
  output logic                     load_fwd_valid,
  output logic [DATA_W-1:0]        load_fwd_data,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  // FIFO storage; payload needs no reset because r_valid qualifies it
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [1:0]        r_size [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;

  logic              r_mem_write;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_size;

  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_head_next;
  logic              w_conflict;

  assign store_accept_ROB = (r_count < FULL_CNT);
  assign w_push           = store_valid_ROB && store_accept_ROB;
  // The issued entry is always the head, so an acknowledge pops it
  assign w_pop            = (r_state == S_ISSUE) && DM_ready;
  assign w_head_next      = r_head + PTR_W'(1);

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_addr[r_tail] <= store_addr_ROB;
      r_data[r_tail] <= store_data_ROB;
      r_size[r_tail] <= store_size_ROB;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_mem_write <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_size  <= '0;
    end else begin
      // push and pop never target the same slot: push needs count<DEPTH,
      // pop needs count>0, so head==tail cannot occur with both active
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= w_head_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_out_addr  <= r_addr[r_head];
            r_out_data  <= r_data[r_head];
            r_out_size  <= r_size[r_head];
            r_mem_write <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (DM_ready) begin
            // Only entries already buffered before this edge are reloaded;
            // a store pushed on the same edge is picked up from IDLE.
            if (r_count > ONE_CNT) begin
              r_out_addr <= r_addr[w_head_next];
              r_out_data <= r_data[w_head_next];
              r_out_size <= r_size[w_head_next];
            end else begin
              r_mem_write <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign MemWrite_2DM        = r_mem_write;
  assign data_address_2DM    = r_out_addr;
  assign data_write_2DM      = r_out_data;
  assign data_write_size_2DM = r_out_size;
  assign sb_count            = r_count;
  assign sb_empty            = (r_count == '0);

  // Word-granular overlap check against registered entries only
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][ADDR_W-1:2] == load_check_addr_MEM[ADDR_W-1:2]))
        w_conflict = 1'b1;
    end
  end
  assign load_conflict = w_conflict;

`ifdef SB_FORWARD_EN
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;

  // Walk from oldest to youngest so the last match found is the youngest
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[r_head + PTR_W'(i)] &&
          (r_addr[r_head + PTR_W'(i)][ADDR_W-1:2] == load_check_addr_MEM[ADDR_W-1:2])) begin
        w_hit     = 1'b1;
        w_hit_idx = r_head + PTR_W'(i);
      end
    end
  end

  // Only a full aligned word store at exactly the load address can supply
  // the load; anything partial leaves the load to wait on load_conflict.
  assign load_fwd_valid = w_hit && (r_size[w_hit_idx] == 2'd0) &&
                          (r_addr[w_hit_idx][1:0] == 2'b00) &&
                          (r_addr[w_hit_idx] == load_check_addr_MEM);
  assign load_fwd_data  = load_fwd_valid ? r_data[w_hit_idx] : '0;
`else
  logic w_unused_lsb;
  assign w_unused_lsb   = ^load_check_addr_MEM[1:0];
  assign load_fwd_valid = 1'b0;
  assign load_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SBW = AW + DW + 2;

`ifdef SB_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic          CLK;
  logic          RESET;
  logic          store_valid_ROB;
  logic [AW-1:0] store_addr_ROB;
  logic [DW-1:0] store_data_ROB;
  logic [1:0]    store_size_ROB;
  logic          store_accept_ROB;
  logic          MemWrite_2DM;
  logic [AW-1:0] data_address_2DM;
  logic [DW-1:0] data_write_2DM;
  logic [1:0]    data_write_size_2DM;
  logic          DM_ready;
  logic [AW-1:0] load_check_addr_MEM;
  logic          load_conflict;
  logic          load_fwd_valid;
  logic [DW-1:0] load_fwd_data;
  logic [3:0]    sb_count;
  logic          sb_empty;

  store_commit_buffer #(.DEPTH(8), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .store_valid_ROB     (store_valid_ROB),
    .store_addr_ROB      (store_addr_ROB),
    .store_data_ROB      (store_data_ROB),
    .store_size_ROB      (store_size_ROB),
    .store_accept_ROB    (store_accept_ROB),
    .MemWrite_2DM        (MemWrite_2DM),
    .data_address_2DM    (data_address_2DM),
    .data_write_2DM      (data_write_2DM),
    .data_write_size_2DM (data_write_size_2DM),
    .DM_ready            (DM_ready),
    .load_check_addr_MEM (load_check_addr_MEM),
    .load_conflict       (load_conflict),
    .load_fwd_valid      (load_fwd_valid),
    .load_fwd_data       (load_fwd_data),
    .sb_count            (sb_count),
    .sb_empty            (sb_empty)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_xfer = 0;
  logic [SBW-1:0] exp_q[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepted writes are compared on the opposite edge, just before the
  // rising edge that completes the handshake.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && MemWrite_2DM === 1'b1 && DM_ready === 1'b1) begin
      logic [SBW-1:0] e;
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 64'(data_address_2DM), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_addr", 64'(data_address_2DM), 64'(e[SBW-1 -: AW]));
        chk("xfer_data", 64'(data_write_2DM), 64'(e[DW+1:2]));
        chk("xfer_size", 64'(data_write_size_2DM), 64'(e[1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] s, input logic expect_accept);
    store_valid_ROB = v;
    store_addr_ROB  = a;
    store_data_ROB  = d;
    store_size_ROB  = s;
    if (v && expect_accept) exp_q.push_back({a, d, s});
  endtask

  // Called from the input-driving slot; returns at the next one
  task automatic wait_drain(string name);
    int n = 0;
    @(negedge CLK);
    while ((sb_empty !== 1'b1 || MemWrite_2DM !== 1'b0) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_in_time"}, 64'(n < 60), 64'd1);
    chk({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    cyc();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    size;
    logic          dm;
    logic [AW-1:0] ld;
    logic          e_acc;
    logic          e_mw;
    logic [3:0]    e_cnt;
    logic          e_cf;
    logic          e_fv;
    logic [DW-1:0] e_fd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vec_t v;

    // row: inputs for the cycle, outputs expected before that cycle's edge
    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 2'd0, 1'b1, 32'h100, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b1, 32'h100, 1'b1, 1'b0, 4'd1, 1'b1, FWD_EN, FWD_EN ? 32'hDEADBEEF : 32'h0};
    vecs[2]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b1, 32'h104, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h204, 32'hA5A50055, 2'd0, 1'b0, 32'h206, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b0, 32'h206, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b0, 32'h208, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b0, 32'h204, 1'b1, 1'b1, 4'd1, 1'b1, FWD_EN, FWD_EN ? 32'hA5A50055 : 32'h0};
    vecs[7]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b1, 32'h207, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h20B, 32'hFFFFFF7E, 2'd1, 1'b1, 32'h208, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b1, 32'h208, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b1, 32'h300, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,   32'h0,        2'd0, 1'b1, 32'h208, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0};

    RESET = 1'b0;
    DM_ready = 1'b0;
    load_check_addr_MEM = 32'hFFFF_0000;
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    repeat (2) cyc();

    // ---- reset state ----
    @(negedge CLK);
    chk("rst_memwrite", 64'(MemWrite_2DM), 64'd0);
    chk("rst_count", 64'(sb_count), 64'd0);
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_accept", 64'(store_accept_ROB), 64'd1);
    chk("rst_addr", 64'(data_address_2DM), 64'd0);
    chk("rst_data", 64'(data_write_2DM), 64'd0);
    chk("rst_size", 64'(data_write_size_2DM), 64'd0);
    chk("rst_conflict", 64'(load_conflict), 64'd0);
    cyc();
    RESET = 1'b1;

    // ---- table-driven vectors ----
    for (int r = 0; r < NV; r++) begin
      v = vecs[r];
      DM_ready = v.dm;
      load_check_addr_MEM = v.ld;
      drive(v.vld, v.addr, v.data, v.size, v.e_acc);
      @(negedge CLK);
      chk($sformatf("vec%0d_accept", r), 64'(store_accept_ROB), 64'(v.e_acc));
      chk($sformatf("vec%0d_memwrite", r), 64'(MemWrite_2DM), 64'(v.e_mw));
      chk($sformatf("vec%0d_count", r), 64'(sb_count), 64'(v.e_cnt));
      chk($sformatf("vec%0d_empty", r), 64'(sb_empty), 64'(v.e_cnt == 4'd0));
      chk($sformatf("vec%0d_conflict", r), 64'(load_conflict), 64'(v.e_cf));
      chk($sformatf("vec%0d_fwd_valid", r), 64'(load_fwd_valid), 64'(v.e_fv));
      chk($sformatf("vec%0d_fwd_data", r), 64'(load_fwd_data), 64'(v.e_fd));
      cyc();
    end
    load_check_addr_MEM = 32'hFFFF_0000;
    drive(1'b0, '0, '0, 2'd0, 1'b0);

    // ---- fill to full with cache stalled, then back-to-back drain ----
    DM_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 32'h1000 + 32'(k * 4), $urandom, 2'($urandom_range(0, 3)), k < 8);
      @(negedge CLK);
      chk($sformatf("fill%0d_accept", k), 64'(store_accept_ROB), 64'(k < 8));
      cyc();
    end
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    @(negedge CLK);
    chk("full_count", 64'(sb_count), 64'd8);
    chk("full_accept", 64'(store_accept_ROB), 64'd0);
    chk("full_memwrite", 64'(MemWrite_2DM), 64'd1);
    cyc();
    DM_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk($sformatf("burst%0d_memwrite", k), 64'(MemWrite_2DM), 64'd1);
      cyc();
    end
    @(negedge CLK);
    chk("burst_done_memwrite", 64'(MemWrite_2DM), 64'd0);
    chk("burst_done_empty", 64'(sb_empty), 64'd1);
    chk("burst_sb_left", 64'(exp_q.size()), 64'd0);
    cyc();

    // ---- stall in ISSUE, then pop with a simultaneous push ----
    DM_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h0A0A0A0A, 2'd2, 1'b1);
    cyc();
    drive(1'b1, 32'h404, 32'h0000000B, 2'd3, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("stall%0d_memwrite", k), 64'(MemWrite_2DM), 64'd1);
      chk($sformatf("stall%0d_addr", k), 64'(data_address_2DM), 64'h400);
      chk($sformatf("stall%0d_data", k), 64'(data_write_2DM), 64'h0A0A0A0A);
      chk($sformatf("stall%0d_size", k), 64'(data_write_size_2DM), 64'd2);
      cyc();
    end
    DM_ready = 1'b1;
    drive(1'b1, 32'h408, 32'hC0C0C0C0, 2'd0, 1'b1);
    @(negedge CLK);
    chk("pushpop_count_before", 64'(sb_count), 64'd2);
    cyc();
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    @(negedge CLK);
    chk("pushpop_count_after", 64'(sb_count), 64'd2);
    chk("pushpop_next_addr", 64'(data_address_2DM), 64'h404);
    cyc();
    wait_drain("stall_drain");

    // ---- forwarding picks the youngest full word ----
    DM_ready = 1'b0;
    drive(1'b1, 32'h300, 32'h11111111, 2'd0, 1'b1);
    cyc();
    drive(1'b1, 32'h300, 32'h22222222, 2'd0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    load_check_addr_MEM = 32'h300;
    @(negedge CLK);
    chk("fwd_word_count", 64'(sb_count), 64'd2);
    chk("fwd_word_conflict", 64'(load_conflict), 64'd1);
    chk("fwd_word_valid", 64'(load_fwd_valid), 64'(FWD_EN));
    chk("fwd_word_data", 64'(load_fwd_data), FWD_EN ? 64'h22222222 : 64'h0);
    cyc();
    drive(1'b1, 32'h300, 32'h00000033, 2'd1, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    @(negedge CLK);
    chk("fwd_byte_count", 64'(sb_count), 64'd3);
    chk("fwd_byte_conflict", 64'(load_conflict), 64'd1);
    chk("fwd_byte_valid", 64'(load_fwd_valid), 64'd0);
    chk("fwd_byte_data", 64'(load_fwd_data), 64'd0);
    cyc();
    load_check_addr_MEM = 32'hFFFF_0000;
    DM_ready = 1'b1;
    wait_drain("fwd_drain");

    // ---- reset mid-drain, then pointer wrap ----
    DM_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h500 + 32'(k * 4), $urandom, 2'd0, 1'b1);
      cyc();
    end
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    @(negedge CLK);
    chk("pre_rst_count", 64'(sb_count), 64'd3);
    chk("pre_rst_memwrite", 64'(MemWrite_2DM), 64'd1);
    cyc();
    RESET = 1'b0;
    DM_ready = 1'b1;
    cyc();
    RESET = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk("mid_rst_memwrite", 64'(MemWrite_2DM), 64'd0);
    chk("mid_rst_count", 64'(sb_count), 64'd0);
    chk("mid_rst_empty", 64'(sb_empty), 64'd1);
    chk("mid_rst_addr", 64'(data_address_2DM), 64'd0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h600 + 32'(k * 4), $urandom, 2'($urandom_range(0, 3)), 1'b1);
      cyc();
    end
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    wait_drain("wrap_drain");

    // 3 from the table, 8 burst, 3 stall, 3 forward, 10 wrap
    chk("xfer_total", 64'(n_xfer), 64'd27);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the ROB commit point and upstream of the data cache.
- Accepts stores in program order as they retire from the ROB head and queues them in a FIFO.
- Drains them to the data cache through a valid/ready handshake, so a busy cache never stalls retirement until the buffer fills.
- Also gives the MEM stage a same-cycle conflict check and, optionally, store-to-load forwarding.

Parameters:
DEPTH, 8, number of buffered stores; power of 2, >= 2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-low reset
store_valid_ROB  in  1  committed store presented this cycle
store_addr_ROB  in  ADDR_W  store byte address
store_data_ROB  in  DATA_W  store data, right-justified
store_size_ROB  in  2  0=word, 1=byte, 2=half, 3=three-byte
store_accept_ROB  out  1  buffer can take a store this cycle
MemWrite_2DM  out  1  write request to data cache
data_address_2DM  out  ADDR_W  write address
data_write_2DM  out  DATA_W  write data
data_write_size_2DM  out  2  write size, same encoding as store_size_ROB
DM_ready  in  1  cache accepts the presented write this cycle
load_check_addr_MEM  in  ADDR_W  address of load in MEM stage
load_conflict  out  1  some buffered store overlaps the load's word
load_fwd_valid  out  1  forwarded data valid (optional feature)
load_fwd_data  out  DATA_W  forwarded data (optional feature)
sb_count  out  clog2(DEPTH)+1  occupied entries
sb_empty  out  1  sb_count==0

Behaviour:
- Storage and pointers:
  - Circular FIFO of {addr, data, size, valid}.
  - head/tail pointers are clog2(DEPTH) bits and wrap naturally.
  - count is a separate register.
- Reset (RESET==0 at rising edge):
  - count=0, head=tail=0, all valid=0, FSM=IDLE.
  - MemWrite_2DM=0; data_address_2DM, data_write_2DM and data_write_size_2DM = 0.
  - A write in flight is abandoned.
  - Reset applied mid-drain takes effect at that edge; no write is presented the following cycle.
- Accept:
  - store_accept_ROB = (count < DEPTH); combinational, independent of DM_ready.
  - Push occurs when store_valid_ROB && store_accept_ROB: entry written at tail, tail+1.
  - store_valid_ROB while full: ignored, no state change.
- Drain FSM, IDLE and ISSUE:
  - IDLE: MemWrite_2DM=0. If count>0 at an edge, load the output registers from the head entry and go to ISSUE.
  - ISSUE: MemWrite_2DM=1 and the outputs hold stable until DM_ready==1.
  - When DM_ready==1 in ISSUE: pop head (valid=0, head+1). If entries remain after the pop, reload the outputs from the new head at the same edge and stay in ISSUE (one store per cycle throughput). Otherwise go to IDLE.
  - The issued entry stays in the FIFO, counting toward count and the conflict check, until it is acknowledged.
- Latency:
  - A store pushed into an empty buffer at edge N gives MemWrite_2DM=1 after edge N+1.
  - With DM_ready held at 1, K stores drain in K cycles.
- Count:
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
  - A push at count==DEPTH is impossible because accept is 0; a same-cycle pop does not enable the push.
- Data is passed through unmodified. data_write_2DM reflects the data exactly as pushed, including any upper bits.
- Conflict:
  - load_conflict=1 iff some valid entry has addr[ADDR_W-1:2] == load_check_addr_MEM[ADDR_W-1:2].
  - Combinational, evaluated against state before the current edge.
  - A same-cycle push is not visible.
- sb_count and sb_empty reflect registered state.

Optional Feature:
Macro: SB_FORWARD_EN
- Defined:
  - Select the youngest valid entry whose word address matches load_check_addr_MEM.
  - If that entry has size==0, addr[1:0]==0 and addr equal to load_check_addr_MEM: load_fwd_valid=1 and load_fwd_data = its data.
  - Otherwise load_fwd_valid=0 and load_fwd_data=0.
  - load_conflict is unchanged.
- Undefined: load_fwd_valid and load_fwd_data are tied to 0; no forwarding logic.

Test Plan:
- Reset, then push a word store (0x100, 0xDEADBEEF, size 0) with DM_ready=1 -> MemWrite_2DM=1 with that address, data and size one cycle later; the next cycle MemWrite_2DM=0 and sb_empty=1.
- DM_ready=0, push 8 stores -> sb_count=8, store_accept_ROB=0. A 9th push is ignored. Raise DM_ready -> the 8 writes appear on 8 consecutive cycles in push order, addresses intact.
- Hold DM_ready=0 during ISSUE for 5 cycles -> outputs stable and MemWrite_2DM=1 throughout. On DM_ready=1 the head pops, and a simultaneous push leaves sb_count unchanged.
- Buffer holds store 0x204; load_check_addr_MEM=0x206 -> load_conflict=1. Load at 0x208 -> load_conflict=0.
- With SB_FORWARD_EN, stores (0x300, 0x11111111) then (0x300, 0x22222222), load at 0x300 -> load_fwd_valid=1, data 0x22222222. Byte store at 0x300 youngest -> load_fwd_valid=0, load_conflict=1.
- RESET low during ISSUE with 3 entries -> next cycle MemWrite_2DM=0, sb_count=0; pointers wrap correctly on the following 10 pushes and drains.
